// File: rtl/cva6_cfg_report_pkg.sv
// Shared definitions for the configuration reporter: FSM state type,
// descriptor layout constants and the elaboration-time descriptor builder.
package cva6_cfg_report_pkg;

  // Default core XLEN of the build configuration.
  localparam int unsigned CVA6ConfigXlen = 64;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_e;

  localparam logic [7:0]  CfgMagic    = 8'hC6;
  localparam int unsigned CfgNumBytes = 7;

  // Bit positions inside descriptor byte 2 (feature flags).
  localparam int unsigned FlagFpu       = 0;
  localparam int unsigned FlagCvxif     = 1;
  localparam int unsigned FlagCExt      = 2;
  localparam int unsigned FlagAExt      = 3;
  localparam int unsigned FlagFetchUser = 4;
  localparam int unsigned FlagDataUser  = 5;
  localparam int unsigned FlagRename    = 6;

  // Bit positions inside descriptor byte 3 (FP formats).
  localparam int unsigned FmtF16    = 0;
  localparam int unsigned FmtF16Alt = 1;
  localparam int unsigned FmtF8     = 2;
  localparam int unsigned FmtFVec   = 3;

  function automatic logic [6:0][7:0] build_descriptor(
    input int unsigned xlen,
    input logic        fpu_en,
    input logic        f16_en,
    input logic        f16alt_en,
    input logic        f8_en,
    input logic        fvec_en,
    input logic        cvxif_en,
    input logic        cext_en,
    input logic        aext_en,
    input logic        rename_en,
    input logic        fetch_user_en,
    input logic        data_user_en,
    input int unsigned fetch_user_width,
    input int unsigned data_user_width
  );
    logic [6:0][7:0] d;
    d    = '0;
    d[0] = CfgMagic;
    d[1] = 8'(xlen);
    d[2][FlagFpu]       = fpu_en;
    d[2][FlagCvxif]     = cvxif_en;
    d[2][FlagCExt]      = cext_en;
    d[2][FlagAExt]      = aext_en;
    d[2][FlagFetchUser] = fetch_user_en;
    d[2][FlagDataUser]  = data_user_en;
    d[2][FlagRename]    = rename_en;
    d[3][FmtF16]        = f16_en;
    d[3][FmtF16Alt]     = f16alt_en;
    d[3][FmtF8]         = f8_en;
    d[3][FmtFVec]       = fvec_en;
    d[4] = 8'(fetch_user_width);
    d[5] = 8'(data_user_width);
    d[6] = d[0] ^ d[1] ^ d[2] ^ d[3] ^ d[4] ^ d[5];
    return d;
  endfunction

endpackage

// File: rtl/cva6_config_reporter.sv
// Streams the constant 7-byte build-configuration descriptor on request.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   req_i           start a transfer (sampled only in IDLE)
//   abort_i         synchronous abort of the transfer in progress
//   valid_o/ready_i byte-wide valid/ready handshake, data on byte_o
//   busy_o          high while in SEND or DONE
//   done_o          one-cycle pulse after the last byte is accepted
module cva6_config_reporter
  import cva6_cfg_report_pkg::*;
#(
  parameter int unsigned Xlen           = CVA6ConfigXlen,
  parameter logic        FpuEn          = 1'b0,
  parameter logic        F16En          = 1'b0,
  parameter logic        F16AltEn       = 1'b0,
  parameter logic        F8En           = 1'b0,
  parameter logic        FVecEn         = 1'b0,
  parameter logic        CvxifEn        = 1'b0,
  parameter logic        CExtEn         = 1'b0,
  parameter logic        AExtEn         = 1'b0,
  parameter logic        RenameEn       = 1'b0,
  parameter logic        FetchUserEn    = 1'b0,
  parameter logic        DataUserEn     = 1'b0,
  parameter int unsigned FetchUserWidth = Xlen,
  parameter int unsigned DataUserWidth  = Xlen
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req_i,
  input  logic       abort_i,
  output logic       valid_o,
  input  logic       ready_i,
  output logic [7:0] byte_o,
  output logic       busy_o,
  output logic       done_o
);

  if (!(Xlen == 32 || Xlen == 64)) begin : g_bad_xlen
    $error("cva6_config_reporter: Xlen must be 32 or 64");
  end
  if (FetchUserWidth < 1 || FetchUserWidth > 255) begin : g_bad_fetch_w
    $error("cva6_config_reporter: FetchUserWidth must be 1..255");
  end
  if (DataUserWidth < 1 || DataUserWidth > 255) begin : g_bad_data_w
    $error("cva6_config_reporter: DataUserWidth must be 1..255");
  end

  localparam logic [6:0][7:0] Desc = build_descriptor(
    Xlen, FpuEn, F16En, F16AltEn, F8En, FVecEn, CvxifEn, CExtEn, AExtEn,
    RenameEn, FetchUserEn, DataUserEn, FetchUserWidth, DataUserWidth);

  localparam logic [2:0] LastIdx = 3'(CfgNumBytes - 1);

  state_e     state_q;
  logic [2:0] idx_q;
  logic       valid_q;
  logic [7:0] byte_q;

  // The next byte is loaded into byte_q on the accepting edge, so byte_o
  // is purely registered and ready_i never reaches it combinationally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      byte_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_i) begin
            state_q <= SEND;
            idx_q   <= '0;
            valid_q <= 1'b1;
            byte_q  <= Desc[0];
          end
        end
        SEND: begin
          // Abort takes priority over a same-cycle handshake.
          if (abort_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            byte_q  <= '0;
          end else if (valid_q && ready_i) begin
            if (idx_q == LastIdx) begin
              state_q <= DONE;
              idx_q   <= '0;
              valid_q <= 1'b0;
              byte_q  <= '0;
            end else begin
              idx_q  <= idx_q + 3'd1;
              byte_q <= Desc[idx_q + 3'd1];
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          idx_q   <= '0;
          valid_q <= 1'b0;
          byte_q  <= '0;
        end
        default: begin
          state_q <= IDLE;
          idx_q   <= '0;
          valid_q <= 1'b0;
          byte_q  <= '0;
        end
      endcase
    end
  end

  assign valid_o = valid_q;
  assign byte_o  = byte_q;
  assign busy_o  = (state_q != IDLE);
  assign done_o  = (state_q == DONE);

  idx_in_range_a: assert property (@(posedge clk_i) disable iff (!rst_ni) idx_q <= LastIdx);

endmodule

// File: tb/tb_cva6_config_reporter.sv
module tb_cva6_config_reporter;

  typedef logic [6:0][7:0] desc_t;
  typedef struct {
    int    dut;
    int    stall;
    desc_t b;
  } vec_t;

  logic clk, rst_n, ready, abort, req0, req1;
  logic       valid0, busy0, done0, valid1, busy1, done1;
  logic [7:0] byte0, byte1;
  logic       sel;
  logic       m_valid, m_busy, m_done;
  logic [7:0] m_byte;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] sbq[$];
  logic       prev_stall;
  logic [7:0] prev_byte;

  // Expected descriptors: default build and RV32 with C and A.
  desc_t def_d, alt_d;
  vec_t  tbl[4];

  cva6_config_reporter u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req0), .abort_i(abort),
    .valid_o(valid0), .ready_i(ready), .byte_o(byte0),
    .busy_o(busy0), .done_o(done0)
  );

  cva6_config_reporter #(
    .Xlen(32), .CExtEn(1'b1), .AExtEn(1'b1),
    .FetchUserWidth(32), .DataUserWidth(32)
  ) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req1), .abort_i(abort),
    .valid_o(valid1), .ready_i(ready), .byte_o(byte1),
    .busy_o(busy1), .done_o(done1)
  );

  assign m_valid = sel ? valid1 : valid0;
  assign m_byte  = sel ? byte1  : byte0;
  assign m_busy  = sel ? busy1  : busy0;
  assign m_done  = sel ? done1  : done0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every accepted byte pops one expected byte.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", {31'd0, m_valid}, 32'd1);
        chk("hold_byte", {24'd0, m_byte}, {24'd0, prev_byte});
      end
      if (m_valid && ready && !abort) begin
        if (sbq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL extra_byte: got %02h, required no byte", m_byte);
        end else begin
          chk("byte", {24'd0, m_byte}, {24'd0, sbq.pop_front()});
        end
      end
      prev_stall = m_valid && !ready;
      prev_byte  = m_byte;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transfer; stall>0 keeps ready low for stall cycles per byte.
  task automatic xfer(input int d, input int stall, input desc_t b);
    int cyc;
    bit seen;
    sel = (d != 0);
    for (int i = 0; i < 7; i++) sbq.push_back(b[i]);
    if (d != 0) req1 = 1'b1; else req0 = 1'b1;
    ready = (stall == 0);
    tick();
    req0 = 1'b0;
    req1 = 1'b0;
    cyc  = 1;
    seen = 0;
    while (!seen && cyc < 200) begin
      ready = (stall == 0) || (cyc % (stall + 1) == 0);
      @(negedge clk);
      chk("busy", {31'd0, m_busy}, 32'd1);
      if (cyc == 1) chk("first_valid", {31'd0, m_valid}, 32'd1);
      if (m_done) begin
        seen = 1;
        if (stall == 0) chk("done_latency", cyc, 8);
      end
      tick();
      cyc++;
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: got no done_o, required done_o within 200 cycles");
    end
    ready = 1'b0;
    @(negedge clk);
    chk("done_pulse", {31'd0, m_done}, 32'd0);
    chk("busy_after", {31'd0, m_busy}, 32'd0);
    chk("valid_after", {31'd0, m_valid}, 32'd0);
    chk("sb_empty", sbq.size(), 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, ndone, nrise, d1, d2, r2;
    logic pv;

    def_d = {8'h86, 8'h40, 8'h40, 8'h00, 8'h00, 8'h40, 8'hC6};
    alt_d = {8'hEA, 8'h20, 8'h20, 8'h00, 8'h0C, 8'h20, 8'hC6};
    tbl[0] = '{dut: 0, stall: 0, b: def_d};
    tbl[1] = '{dut: 1, stall: 0, b: alt_d};
    tbl[2] = '{dut: 0, stall: 3, b: def_d};
    tbl[3] = '{dut: 1, stall: 1, b: alt_d};

    clk = 0; rst_n = 0; ready = 0; abort = 0; req0 = 0; req1 = 0; sel = 0;
    #12;
    chk("rst_valid0", {31'd0, valid0}, 32'd0);
    chk("rst_byte0", {24'd0, byte0}, 32'd0);
    chk("rst_busy0", {31'd0, busy0}, 32'd0);
    chk("rst_done0", {31'd0, done0}, 32'd0);
    chk("rst_valid1", {31'd0, valid1}, 32'd0);
    chk("rst_busy1", {31'd0, busy1}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    tick();

    for (int i = 0; i < 4; i++) xfer(tbl[i].dut, tbl[i].stall, tbl[i].b);

    // req held high: one transfer per IDLE entry, restart after DONE.
    sel = 0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 7; i++) sbq.push_back(def_d[i]);
    ready = 1; req0 = 1;
    cyc = 0; ndone = 0; nrise = 0; d1 = 0; d2 = 0; r2 = 0; pv = 0;
    while (cyc < 24) begin
      tick();
      cyc++;
      @(negedge clk);
      if (m_done) begin
        ndone++;
        if (ndone == 1) d1 = cyc; else d2 = cyc;
        if (ndone == 2) req0 = 0;
      end
      if (m_valid && !pv) begin
        nrise++;
        if (nrise == 2) r2 = cyc;
      end
      pv = m_valid;
    end
    req0 = 0;
    chk("held_ndone", ndone, 2);
    chk("held_done1", d1, 8);
    chk("held_restart", r2, 10);
    chk("held_done2", d2, 17);
    chk("held_sb_empty", sbq.size(), 0);
    ready = 0;
    tick();

    // Abort at index 3 together with ready.
    for (int i = 0; i < 3; i++) sbq.push_back(def_d[i]);
    ready = 1; req0 = 1;
    tick();
    req0 = 0;
    repeat (3) tick();
    chk("abort_idx3_byte", {24'd0, byte0}, {24'd0, def_d[3]});
    abort = 1;
    tick();
    abort = 0;
    chk("abort_valid", {31'd0, valid0}, 32'd0);
    chk("abort_busy", {31'd0, busy0}, 32'd0);
    chk("abort_done", {31'd0, done0}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", {31'd0, done0}, 32'd0);
      tick();
    end
    chk("abort_sb_empty", sbq.size(), 0);
    xfer(0, 0, def_d);

    // Asynchronous reset with byte index 4 on the output.
    for (int i = 0; i < 4; i++) sbq.push_back(def_d[i]);
    ready = 1; req0 = 1;
    tick();
    req0 = 0;
    repeat (4) tick();
    chk("pre_rst_byte", {24'd0, byte0}, {24'd0, def_d[4]});
    #1 rst_n = 0;
    #1;
    chk("rst_mid_valid", {31'd0, valid0}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy0}, 32'd0);
    chk("rst_mid_byte", {24'd0, byte0}, 32'd0);
    ready = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    tick();
    chk("post_rst_valid", {31'd0, valid0}, 32'd0);
    chk("post_rst_busy", {31'd0, busy0}, 32'd0);
    chk("post_rst_done", {31'd0, done0}, 32'd0);
    chk("post_rst_sb", sbq.size(), 0);
    xfer(0, 0, def_d);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
